// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction register, fetching one word per instruction over req/ready
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET  = 32'h0040_0000,
   parameter bit          IMEM_WAIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  func,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        advance,
   input  logic        jump,
   input  logic        jr,
   input  logic        brancheq,
   input  logic        branchne,
   input  logic        zero,
   input  logic [31:0] rs_data,
   output logic        addr_err
);
   typedef enum logic [1:0] {IDLE, FETCH, CAPT, HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, br_off;
   logic        imem_req_q, imem_req_d, instr_valid_q, instr_valid_d, addr_err_q, addr_err_d, taken;
   assign pc_plus4    = pc_q + 32'd4;
   assign taken       = (brancheq & zero) | (branchne & ~zero);
   assign br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign next_pc     = jr    ? {rs_data[31:2], 2'b00} :
                        jump  ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                        taken ? pc_plus4 + br_off : pc_plus4;
   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign func        = instr_q[5:0];
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign addr_err    = addr_err_q;
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = instr_valid_q;
      addr_err_d    = addr_err_q;
      case (state_q)
         IDLE: begin
            state_d    = FETCH;
            imem_req_d = 1'b1;
         end
         FETCH: if (imem_ready) begin
            imem_req_d = 1'b0;
            if (IMEM_WAIT) state_d = CAPT;
            else begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         CAPT: begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
         end
         HOLD: if (advance) begin
            pc_d          = next_pc;
            instr_valid_d = 1'b0;
            imem_req_d    = 1'b1;
            state_d       = FETCH;
            addr_err_d    = addr_err_q | (jr & (rs_data[1:0] != 2'b00));
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= PC_RESET;
         instr_q       <= 32'd0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         addr_err_q    <= addr_err_d;
      end
   end
endmodule
